controle_elevador: RTL and testbench
====================================

// Module: controle_elevador
// PURPOSE
//  Elevator sequencing controller. Latches floor-call buttons into a pending-request register.
//  Drives the current-floor counter with SCAN (keep direction while calls remain ahead).
//  Opens the door on arrival and clears the served call.
//  Owns the per-floor request flip-flops that estadoclear-style clear masks act on.
//  Sits between the button/pare inputs and the floor display/motor outputs.
// PARAMETERS
//  N_ANDARES   16  number of floors; floor index width W = $clog2(N_ANDARES) = 4
//  T_VIAGEM    8   clock cycles to travel one floor (>=1)
//  T_PORTA     20  clock cycles the door stays open (>=1)
// PORTS
//  clk           in   1   system clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  botao         in   16  floor-call buttons, level or pulse; bit k = call to floor k
//  pare          in   1   emergency stop, level, highest priority
//  andar_atual   out  4   current floor
//  subindo       out  1   motor up (state MOVENDO, dir=up)
//  descendo      out  1   motor down (state MOVENDO, dir=down)
//  porta_aberta  out  1   door open (state PORTA)
//  pendentes     out  16  pending-call register
//  ocupado       out  1   1 when state != OCIOSO
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=OCIOSO, andar_atual=0, dir=up, pendentes=0, timer=0; all outputs 0.
//  Request register, every cycle:
//   - pendentes <= (pendentes | botao) & ~clr.
//   - clr = onehot(andar_atual) while state==PORTA, else 0. Clear wins over a same-cycle set at that floor.
//  Decision function dec (evaluated from OCIOSO, end of PORTA, and on each floor arrival):
//   - pendentes[andar] -> PORTA.
//   - else calls ahead in dir -> MOVENDO, same dir.
//   - else calls behind -> MOVENDO, dir flipped.
//   - else -> OCIOSO.
//   - "ahead" for up = any bit above andar; for down = any bit below. Dir only flips here.
//  States:
//   - OCIOSO: apply dec each cycle. Entering MOVENDO loads timer=T_VIAGEM-1.
//   - MOVENDO: timer decrements each cycle. At timer==0, andar_atual += / -= 1 and dec is applied
//     to the new floor in the same edge. A continued move reloads T_VIAGEM-1.
//     Floor changes exactly every T_VIAGEM cycles.
//   - PORTA: entry loads timer=T_PORTA-1. botao at the current floor during PORTA reloads the timer
//     (door re-open). At timer==0, apply dec; pendentes[andar] is already 0.
//   - PARADO: entered from any state the cycle after pare=1. Motor, door and timer are forced to 0.
//     andar_atual is frozen and a partial move is discarded. pendentes keeps latching botao.
//     pare=0 -> OCIOSO.
//  Latency:
//   - botao sampled at edge t -> pendentes at t+1 -> OCIOSO decision -> state change at t+2.
//  Boundaries:
//   - andar_atual never wraps: no up move at N_ANDARES-1, no down move at 0. Guaranteed by dec; asserted.
//   - Call at the current floor while OCIOSO -> PORTA, no motion.
//   - Simultaneous calls above and below while idle -> current dir wins.
//   - rst_n low mid-move or with the door open -> immediate reset values; calls are lost.
//  Outputs are registered or decoded from registered state only; no combinational path from botao or pare.
// STRUCTURE
//  - Package elevador_pkg: estado_t enum {OCIOSO, MOVENDO, PORTA, PARADO}, N_ANDARES, W.
//  - Package also holds the onehot/"calls above/below" mask functions, shared with estadoclear users.
//  - Sub-module temporizador_elevador: loadable down-counter (load, valor, zero flag).
//    One instance is shared by travel and door timing.
//  - The rest is FSM plus pendentes register in the top.
// TESTING
//  1 Reset at floor 0, botao[3] pulsed one cycle (T_VIAGEM=8, T_PORTA=20):
//    - subindo rises 2 cycles later; andar_atual = 1, 2, 3 at +8, +16, +24 cycles.
//    - porta_aberta=1 for 20 cycles; pendentes[3] = 0 one cycle after door opens.
//  2 At floor 5 going up, calls 9 and 2:
//    - serves 9 first, door opens, then descendo to 2.
//    - 2 reached 7*8 cycles after door at 9 closes.
//  3 Idle at 4, botao[4]: porta_aberta next+1 cycle, no subindo/descendo.
//    - botao[4] again during door -> door open 20 cycles from that press.
//  4 pare=1 midway between 6 and 7 moving up:
//    - PARADO next cycle; andar_atual stays 6, motor and door 0.
//    - botao[1] still latched. pare=0 -> resumes, reaches 7 after full 8 cycles.
//  5 At floor 15 with only call 15: no up move, door opens. At floor 0, down never asserted; wrap assertions hold.
//  6 rst_n pulsed low while descending with pendentes=0x00F0:
//    - all outputs 0 asynchronously, andar_atual=0, pendentes=0.

Source files
------------

// File: rtl/elevador_pkg.sv
// Shared types and helpers for the elevator controller: state encoding,
// travel direction, and the per-floor masks that clear/scan logic works on.
package elevador_pkg;

  localparam int N_ANDARES = 16;
  localparam int W         = $clog2(N_ANDARES);

  localparam logic [W-1:0] ANDAR_TERREO = '0;
  localparam logic [W-1:0] ANDAR_TOPO   = W'(N_ANDARES - 1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    MOVENDO = 2'd1,
    PORTA   = 2'd2,
    PARADO  = 2'd3
  } estado_t;

  typedef enum logic {
    SOBE  = 1'b0,
    DESCE = 1'b1
  } direcao_t;

  // Outcome of the scan decision: where to go next and in which direction.
  typedef struct packed {
    estado_t  estado;
    direcao_t dir;
  } decisao_t;

  // One bit set at the given floor; used as the call-clear mask.
  function automatic logic [N_ANDARES-1:0] onehot(input logic [W-1:0] andar);
    logic [N_ANDARES-1:0] m;
    m        = '0;
    m[andar] = 1'b1;
    return m;
  endfunction

  // Bits strictly above the given floor.
  function automatic logic [N_ANDARES-1:0] mascara_acima(input logic [W-1:0] andar);
    logic [N_ANDARES-1:0] m;
    for (int k = 0; k < N_ANDARES; k++) begin
      m[k] = (k > int'(andar));
    end
    return m;
  endfunction

  // Bits strictly below the given floor.
  function automatic logic [N_ANDARES-1:0] mascara_abaixo(input logic [W-1:0] andar);
    logic [N_ANDARES-1:0] m;
    for (int k = 0; k < N_ANDARES; k++) begin
      m[k] = (k < int'(andar));
    end
    return m;
  endfunction

  // SCAN decision: serve the current floor, else keep going while calls
  // remain ahead, else turn around, else rest. Direction only flips here.
  function automatic decisao_t decide(input logic [N_ANDARES-1:0] pend,
                                      input logic [W-1:0]         andar,
                                      input direcao_t             dir);
    decisao_t d;
    logic     acima;
    logic     abaixo;
    logic     frente;
    logic     tras;
    acima  = |(pend & mascara_acima(andar));
    abaixo = |(pend & mascara_abaixo(andar));
    frente = (dir == SOBE) ? acima  : abaixo;
    tras   = (dir == SOBE) ? abaixo : acima;
    d.dir  = dir;
    if (pend[andar]) begin
      d.estado = PORTA;
    end else if (frente) begin
      d.estado = MOVENDO;
    end else if (tras) begin
      d.estado = MOVENDO;
      d.dir    = (dir == SOBE) ? DESCE : SOBE;
    end else begin
      d.estado = OCIOSO;
    end
    return d;
  endfunction

endpackage

// File: rtl/temporizador_elevador.sv
// Loadable down-counter shared by floor-travel and door-open timing.
// Counts down to zero and holds there; clear beats load.
module temporizador_elevador #(
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          carga,
  input  logic          limpa,
  input  logic [TW-1:0] valor,
  output logic          zero
);

  logic [TW-1:0] contagem;

  // Down-count with clear/load priority; saturates at zero.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contagem <= '0;
    end else if (limpa) begin
      contagem <= '0;
    end else if (carga) begin
      contagem <= valor;
    end else if (contagem != '0) begin
      contagem <= contagem - TW'(1);
    end
  end

  assign zero = (contagem == '0);

endmodule

// File: rtl/controle_elevador.sv
// Elevator sequencing controller: latches floor calls, moves the car with
// SCAN ordering, opens the door on arrival and clears the served call.
// Emergency stop freezes the car; all outputs come from registers.
module controle_elevador
  import elevador_pkg::*;
#(
  parameter int T_VIAGEM = 8,
  parameter int T_PORTA  = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_ANDARES-1:0] botao,
  input  logic                 pare,
  output logic [W-1:0]         andar_atual,
  output logic                 subindo,
  output logic                 descendo,
  output logic                 porta_aberta,
  output logic [N_ANDARES-1:0] pendentes,
  output logic                 ocupado
);

  // The shared timer must hold the larger of the two reload values.
  localparam int T_MAX = (T_VIAGEM > T_PORTA) ? T_VIAGEM : T_PORTA;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0] CARGA_VIAGEM = TW'(T_VIAGEM - 1);
  localparam logic [TW-1:0] CARGA_PORTA  = TW'(T_PORTA - 1);

  estado_t              estado;
  direcao_t             dir;
  logic [W-1:0]         andar_seguinte;
  decisao_t             dec_aqui;
  decisao_t             dec_chegada;
  decisao_t             dec_sel;
  logic                 ponto_decisao;
  logic                 chegada;
  logic                 reabre;
  logic                 carga;
  logic                 limpa;
  logic                 zero;
  logic [TW-1:0]        valor;
  logic [N_ANDARES-1:0] clr;

  // Floor the car reaches when the current travel interval expires.
  assign andar_seguinte = (dir == SOBE) ? andar_atual + W'(1) : andar_atual - W'(1);

  // Decision for staying at this floor and for the floor being arrived at.
  assign dec_aqui    = decide(pendentes, andar_atual, dir);
  assign dec_chegada = decide(pendentes, andar_seguinte, dir);

  // The served call is cleared for as long as the door is open.
  assign clr = (estado == PORTA) ? onehot(andar_atual) : '0;

  // Call register: set by any button, cleared at the open-door floor (clear wins).
  // NOTE: the call register is reset: calls pending at reset must be lost, not replayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendentes <= '0;
    end else begin
      pendentes <= (pendentes | botao) & ~clr;
    end
  end

  // Identify decision points and door re-open requests for the current state.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ponto_decisao = 1'b0;
    chegada       = 1'b0;
    reabre        = 1'b0;
    dec_sel       = dec_aqui;
    case (estado)
      OCIOSO: begin
        ponto_decisao = 1'b1;
      end
      MOVENDO: begin
        if (zero) begin
          ponto_decisao = 1'b1;
          chegada       = 1'b1;
          dec_sel       = dec_chegada;
        end
      end
      PORTA: begin
        if (botao[andar_atual]) begin
          reabre = 1'b1;
        end else if (zero) begin
          ponto_decisao = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Timer commands: load on entering MOVENDO/PORTA or on re-open, clear while stopped.
  always_comb begin
    limpa = pare || (estado == PARADO);
    carga = !limpa && (reabre || (ponto_decisao && (dec_sel.estado != OCIOSO)));
    valor = (reabre || (dec_sel.estado == PORTA)) ? CARGA_PORTA : CARGA_VIAGEM;
  end

  temporizador_elevador #(
    .TW (TW)
  ) u_temporizador (
    .clk   (clk),
    .rst_n (rst_n),
    .carga (carga),
    .limpa (limpa),
    .valor (valor),
    .zero  (zero)
  );

  // Main FSM with registered motor/door/busy outputs; stop overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado       <= OCIOSO;
      dir          <= SOBE;
      andar_atual  <= '0;
      subindo      <= 1'b0;
      descendo     <= 1'b0;
      porta_aberta <= 1'b0;
      ocupado      <= 1'b0;
    end else if (pare) begin
      estado       <= PARADO;
      subindo      <= 1'b0;
      descendo     <= 1'b0;
      porta_aberta <= 1'b0;
      ocupado      <= 1'b1;
    end else begin
      case (estado)
        PARADO: begin
          estado  <= OCIOSO;
          ocupado <= 1'b0;
        end
        default: begin
          if (ponto_decisao) begin
            estado       <= dec_sel.estado;
            dir          <= dec_sel.dir;
            subindo      <= (dec_sel.estado == MOVENDO) && (dec_sel.dir == SOBE);
            descendo     <= (dec_sel.estado == MOVENDO) && (dec_sel.dir == DESCE);
            porta_aberta <= (dec_sel.estado == PORTA);
            ocupado      <= (dec_sel.estado != OCIOSO);
            if (chegada) begin
              andar_atual <= andar_seguinte;
            end
          end
        end
      endcase
    end
  end

  // The car must never be commanded past the top or bottom floor.
  a_sem_volta_topo : assert property (@(posedge clk) disable iff (!rst_n)
    !((estado == MOVENDO) && (dir == SOBE) && (andar_atual == ANDAR_TOPO)));

  a_sem_volta_terreo : assert property (@(posedge clk) disable iff (!rst_n)
    !((estado == MOVENDO) && (dir == DESCE) && (andar_atual == ANDAR_TERREO)));

endmodule

// File: tb/tb_controle_elevador.sv
// Directed testbench for controle_elevador (T_VIAGEM=8, T_PORTA=20).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_controle_elevador;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] botao = '0;
  logic        pare = 1'b0;
  logic [3:0]  andar_atual;
  logic        subindo;
  logic        descendo;
  logic        porta_aberta;
  logic [15:0] pendentes;
  logic        ocupado;

  int total = 0;
  int bad   = 0;

  controle_elevador #(
    .T_VIAGEM (8),
    .T_PORTA  (20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .botao        (botao),
    .pare         (pare),
    .andar_atual  (andar_atual),
    .subindo      (subindo),
    .descendo     (descendo),
    .porta_aberta (porta_aberta),
    .pendentes    (pendentes),
    .ocupado      (ocupado)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulso(input logic [15:0] b);
    botao = b;
    tick(1);
    botao = '0;
  endtask

  task automatic espera_andar(input logic [3:0] alvo, input int limite, input string nome);
    int n;
    n = 0;
    while (andar_atual !== alvo && n < limite) begin
      tick(1);
      n++;
    end
    total++;
    if (andar_atual !== alvo) begin
      bad++;
      $display("FAIL %s: timeout, andar_atual=%0d expected=%0d", nome, andar_atual, alvo);
    end
  endtask

  task automatic espera_porta(input logic v, input int limite, input string nome);
    int n;
    n = 0;
    while (porta_aberta !== v && n < limite) begin
      tick(1);
      n++;
    end
    total++;
    if (porta_aberta !== v) begin
      bad++;
      $display("FAIL %s: timeout, porta_aberta=%b expected=%b", nome, porta_aberta, v);
    end
  endtask

  task automatic espera_ocioso(input int limite, input string nome);
    int n;
    n = 0;
    while (ocupado !== 1'b0 && n < limite) begin
      tick(1);
      n++;
    end
    total++;
    if (ocupado !== 1'b0) begin
      bad++;
      $display("FAIL %s: timeout, ocupado=%b expected=0", nome, ocupado);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    botao = 16'h00FF;
    pare  = 1'b0;
    tick(2);
    total++; if (andar_atual !== 4'd0) begin bad++; $display("FAIL rst_andar: got=%0d exp=0", andar_atual); end
    total++; if (subindo !== 1'b0) begin bad++; $display("FAIL rst_subindo: got=%b exp=0", subindo); end
    total++; if (descendo !== 1'b0) begin bad++; $display("FAIL rst_descendo: got=%b exp=0", descendo); end
    total++; if (porta_aberta !== 1'b0) begin bad++; $display("FAIL rst_porta: got=%b exp=0", porta_aberta); end
    total++; if (pendentes !== 16'h0000) begin bad++; $display("FAIL rst_pendentes: got=%h exp=0000", pendentes); end
    total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL rst_ocupado: got=%b exp=0", ocupado); end
    botao = '0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL rst_rel_ocupado: got=%b exp=0", ocupado); end
    total++; if (pendentes !== 16'h0000) begin bad++; $display("FAIL rst_rel_pend: got=%h exp=0000", pendentes); end
  endtask

  // Floor 0 -> 3: latency, travel timing, door length, call clear.
  task automatic test_primeira_viagem;
    pulso(16'h0008);
    total++; if (pendentes !== 16'h0008) begin bad++; $display("FAIL t1_pend_set: got=%h exp=0008", pendentes); end
    total++; if (subindo !== 1'b0) begin bad++; $display("FAIL t1_sub_early: got=%b exp=0", subindo); end
    tick(1);
    total++; if (subindo !== 1'b1) begin bad++; $display("FAIL t1_sub_rise: got=%b exp=1", subindo); end
    total++; if (ocupado !== 1'b1) begin bad++; $display("FAIL t1_ocupado: got=%b exp=1", ocupado); end
    tick(7);
    total++; if (andar_atual !== 4'd0) begin bad++; $display("FAIL t1_andar0_hold: got=%0d exp=0", andar_atual); end
    tick(1);
    total++; if (andar_atual !== 4'd1) begin bad++; $display("FAIL t1_andar1: got=%0d exp=1", andar_atual); end
    tick(8);
    total++; if (andar_atual !== 4'd2) begin bad++; $display("FAIL t1_andar2: got=%0d exp=2", andar_atual); end
    tick(8);
    total++; if (andar_atual !== 4'd3) begin bad++; $display("FAIL t1_andar3: got=%0d exp=3", andar_atual); end
    total++; if (porta_aberta !== 1'b1) begin bad++; $display("FAIL t1_porta_abre: got=%b exp=1", porta_aberta); end
    total++; if (subindo !== 1'b0) begin bad++; $display("FAIL t1_sub_fall: got=%b exp=0", subindo); end
    total++; if (pendentes !== 16'h0008) begin bad++; $display("FAIL t1_pend_open: got=%h exp=0008", pendentes); end
    tick(1);
    total++; if (pendentes !== 16'h0000) begin bad++; $display("FAIL t1_pend_clr: got=%h exp=0000", pendentes); end
    tick(18);
    total++; if (porta_aberta !== 1'b1) begin bad++; $display("FAIL t1_porta_last: got=%b exp=1", porta_aberta); end
    tick(1);
    total++; if (porta_aberta !== 1'b0) begin bad++; $display("FAIL t1_porta_close: got=%b exp=0", porta_aberta); end
    total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL t1_idle: got=%b exp=0", ocupado); end
  endtask

  // Going up past 5 with calls 9 and 2: serve 9 first, then reverse to 2.
  task automatic test_scan;
    pulso(16'h0200);
    espera_andar(4'd5, 40, "t2_reach5");
    pulso(16'h0004);
    total++; if (pendentes !== 16'h0204) begin bad++; $display("FAIL t2_pend: got=%h exp=0204", pendentes); end
    total++; if (subindo !== 1'b1) begin bad++; $display("FAIL t2_sub: got=%b exp=1", subindo); end
    espera_porta(1'b1, 60, "t2_door9");
    total++; if (andar_atual !== 4'd9) begin bad++; $display("FAIL t2_andar9: got=%0d exp=9", andar_atual); end
    espera_porta(1'b0, 30, "t2_close9");
    total++; if (descendo !== 1'b1) begin bad++; $display("FAIL t2_desc: got=%b exp=1", descendo); end
    total++; if (pendentes !== 16'h0004) begin bad++; $display("FAIL t2_pend2: got=%h exp=0004", pendentes); end
    tick(55);
    total++; if (andar_atual !== 4'd3) begin bad++; $display("FAIL t2_andar3: got=%0d exp=3", andar_atual); end
    tick(1);
    total++; if (andar_atual !== 4'd2) begin bad++; $display("FAIL t2_andar2: got=%0d exp=2", andar_atual); end
    total++; if (porta_aberta !== 1'b1) begin bad++; $display("FAIL t2_door2: got=%b exp=1", porta_aberta); end
    espera_ocioso(30, "t2_idle");
  endtask

  // Idle at 4: call at own floor opens the door without motion; re-press extends it.
  task automatic test_porta_local;
    pulso(16'h0010);
    espera_porta(1'b1, 40, "t3_door4");
    total++; if (andar_atual !== 4'd4) begin bad++; $display("FAIL t3_andar4: got=%0d exp=4", andar_atual); end
    espera_ocioso(30, "t3_idle_a");
    pulso(16'h0010);
    total++; if (porta_aberta !== 1'b0) begin bad++; $display("FAIL t3_porta_early: got=%b exp=0", porta_aberta); end
    total++; if (pendentes !== 16'h0010) begin bad++; $display("FAIL t3_pend: got=%h exp=0010", pendentes); end
    tick(1);
    total++; if (porta_aberta !== 1'b1) begin bad++; $display("FAIL t3_porta: got=%b exp=1", porta_aberta); end
    total++; if ({subindo, descendo} !== 2'b00) begin bad++; $display("FAIL t3_motor: got=%b%b exp=00", subindo, descendo); end
    tick(5);
    pulso(16'h0010);
    total++; if (pendentes !== 16'h0000) begin bad++; $display("FAIL t3_clr_wins: got=%h exp=0000", pendentes); end
    tick(14);
    total++; if (porta_aberta !== 1'b1) begin bad++; $display("FAIL t3_reopen_hold: got=%b exp=1", porta_aberta); end
    tick(5);
    total++; if (porta_aberta !== 1'b1) begin bad++; $display("FAIL t3_reopen_last: got=%b exp=1", porta_aberta); end
    tick(1);
    total++; if (porta_aberta !== 1'b0) begin bad++; $display("FAIL t3_reopen_close: got=%b exp=0", porta_aberta); end
  endtask

  // Emergency stop midway 6->7: freeze, keep latching, resume with a full interval.
  task automatic test_pare;
    pulso(16'h0200);
    espera_andar(4'd6, 40, "t4_reach6");
    tick(3);
    pare = 1'b1;
    tick(1);
    total++; if ({subindo, descendo, porta_aberta} !== 3'b000) begin bad++; $display("FAIL t4_outs: got=%b%b%b exp=000", subindo, descendo, porta_aberta); end
    total++; if (andar_atual !== 4'd6) begin bad++; $display("FAIL t4_andar: got=%0d exp=6", andar_atual); end
    total++; if (ocupado !== 1'b1) begin bad++; $display("FAIL t4_ocupado: got=%b exp=1", ocupado); end
    pulso(16'h0002);
    total++; if (pendentes !== 16'h0202) begin bad++; $display("FAIL t4_pend: got=%h exp=0202", pendentes); end
    tick(10);
    total++; if (andar_atual !== 4'd6) begin bad++; $display("FAIL t4_frozen: got=%0d exp=6", andar_atual); end
    pare = 1'b0;
    tick(1);
    total++; if ({ocupado, subindo} !== 2'b00) begin bad++; $display("FAIL t4_ocioso: got=%b%b exp=00", ocupado, subindo); end
    tick(1);
    total++; if (subindo !== 1'b1) begin bad++; $display("FAIL t4_resume: got=%b exp=1", subindo); end
    tick(7);
    total++; if (andar_atual !== 4'd6) begin bad++; $display("FAIL t4_full_interval: got=%0d exp=6", andar_atual); end
    tick(1);
    total++; if (andar_atual !== 4'd7) begin bad++; $display("FAIL t4_andar7: got=%0d exp=7", andar_atual); end
    espera_porta(1'b1, 30, "t4_door9");
    total++; if (andar_atual !== 4'd9) begin bad++; $display("FAIL t4_andar9: got=%0d exp=9", andar_atual); end
    espera_andar(4'd1, 200, "t4_reach1");
    espera_ocioso(40, "t4_idle");
  endtask

  // Top and bottom floors: own-floor calls never move the car past the ends.
  task automatic test_limites;
    int n_mov;
    pulso(16'h8000);
    espera_porta(1'b1, 200, "t5_door15");
    total++; if (andar_atual !== 4'd15) begin bad++; $display("FAIL t5_andar15: got=%0d exp=15", andar_atual); end
    espera_ocioso(40, "t5_idle15");
    pulso(16'h8000);
    tick(1);
    total++; if (porta_aberta !== 1'b1) begin bad++; $display("FAIL t5_porta15: got=%b exp=1", porta_aberta); end
    n_mov = 0;
    for (int i = 0; i < 25; i++) begin
      if (subindo === 1'b1 || andar_atual !== 4'd15) n_mov++;
      tick(1);
    end
    total++; if (n_mov !== 0) begin bad++; $display("FAIL t5_no_up: got=%0d exp=0", n_mov); end
    total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL t5_idle_top: got=%b exp=0", ocupado); end
    pulso(16'h0001);
    espera_porta(1'b1, 200, "t5_door0");
    total++; if (andar_atual !== 4'd0) begin bad++; $display("FAIL t5_andar0: got=%0d exp=0", andar_atual); end
    espera_ocioso(40, "t5_idle0");
    pulso(16'h0001);
    tick(1);
    total++; if (porta_aberta !== 1'b1) begin bad++; $display("FAIL t5_porta0: got=%b exp=1", porta_aberta); end
    n_mov = 0;
    for (int i = 0; i < 25; i++) begin
      if (descendo === 1'b1 || andar_atual !== 4'd0) n_mov++;
      tick(1);
    end
    total++; if (n_mov !== 0) begin bad++; $display("FAIL t5_no_down: got=%0d exp=0", n_mov); end
  endtask

  // Asynchronous reset while descending with calls 4..7 pending.
  task automatic test_reset_assincrono;
    pulso(16'h0400);
    espera_porta(1'b1, 150, "t6_door10");
    total++; if (andar_atual !== 4'd10) begin bad++; $display("FAIL t6_andar10: got=%0d exp=10", andar_atual); end
    tick(3);
    pulso(16'h00F0);
    espera_porta(1'b0, 30, "t6_close10");
    total++; if (descendo !== 1'b1) begin bad++; $display("FAIL t6_desc: got=%b exp=1", descendo); end
    total++; if (pendentes !== 16'h00F0) begin bad++; $display("FAIL t6_pend: got=%h exp=00f0", pendentes); end
    tick(10);
    total++; if (andar_atual !== 4'd9) begin bad++; $display("FAIL t6_andar9: got=%0d exp=9", andar_atual); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (andar_atual !== 4'd0) begin bad++; $display("FAIL t6_async_andar: got=%0d exp=0", andar_atual); end
    total++; if ({subindo, descendo, porta_aberta, ocupado} !== 4'b0000) begin bad++; $display("FAIL t6_async_outs: got=%b%b%b%b exp=0000", subindo, descendo, porta_aberta, ocupado); end
    total++; if (pendentes !== 16'h0000) begin bad++; $display("FAIL t6_async_pend: got=%h exp=0000", pendentes); end
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    total++; if ({ocupado, andar_atual} !== 5'b0_0000) begin bad++; $display("FAIL t6_after: ocupado=%b andar=%0d exp=0/0", ocupado, andar_atual); end
    total++; if (pendentes !== 16'h0000) begin bad++; $display("FAIL t6_calls_lost: got=%h exp=0000", pendentes); end
  endtask

  initial begin
    test_reset();
    test_primeira_viagem();
    test_scan();
    test_porta_local();
    test_pare();
    test_limites();
    test_reset_assincrono();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
